// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush sequencer for a 5-stage MIPS pipeline. It sits beside
// the datapath, watches pipeline-register fields and drives the hold/flush
// enables of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//   * load-use hazard : hold PC and IF/ID for one cycle, bubble into ID/EX
//   * taken redirect  : squash the two wrong-path instructions (IF/ID, ID/EX)
//   * slow data memory: freeze the whole pipeline until mem_ready, with a
//                       WAIT_MAX-cycle timeout that drops the access and sets
//                       a sticky error flag
//
// Optional build macro:
//   HAZ_PERF_CNT_EN - when defined, stall_cnt / flush_cnt are saturating
//                     performance counters; otherwise both are tied to zero
//                     and no counter flops exist.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous active-low reset
//   id_rs/id_rt    source register fields of the instruction in ID
//   id_uses_rt     ID instruction actually reads rt
//   ex_memtoreg    MemtoReg of the EX instruction (2'b01 = load)
//   ex_rf          destination register of the EX instruction
//   ex_pcsrc       PCSrc resolved in EX (nonzero = redirect)
//   mem_memwr      MEM instruction is a store
//   mem_memrd      MEM instruction is a load
//   mem_ready      data memory completes the current access this cycle
//   mem_req        data memory request
//   stall_*        hold enables of PC / IF/ID / ID/EX / EX/MEM
//   flush_ifid     clear IF/ID to nop
//   flush_idex     clear ID/EX to bubble
//   bubble_memwb   load a bubble into MEM/WB
//   mem_err        sticky memory timeout flag
//   state_o        current sequencer state (RUN/MEM_WAIT/MEM_ERR)
//   stall_cnt      cycles with stall_pc asserted
//   flush_cnt      cycles with flush_ifid asserted
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [1:0]       ex_memtoreg,
    input  logic [4:0]       ex_rf,
    input  logic [1:0]       ex_pcsrc,
    input  logic             mem_memwr,
    input  logic             mem_memrd,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             stall_idex,
    output logic             stall_exmem,
    output logic             bubble_memwb,
    output logic             mem_err,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Wide enough to hold the value WAIT_MAX itself.
    localparam int WCNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(WAIT_MAX);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_MEM_ERR  = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_t;

    state_t              state_q,    state_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_err_q,  mem_err_d;

    logic mem_access;
    logic access_state;
    logic load_use;
    logic redirect;
    logic freeze;

    // ------------------------------------------------------------------
    // Hazard decode
    // ------------------------------------------------------------------
    always_comb begin
        mem_access   = mem_memrd | mem_memwr;
        // MEM_ERR drops the access; the illegal encoding is treated the same
        // way for the one cycle it can exist before returning to RUN.
        access_state = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
        freeze       = access_state & mem_access & ~mem_ready;
        redirect     = (ex_pcsrc != 2'b00);
        // $0 is never a real producer, so a load to it cannot create a hazard.
        load_use     = (ex_memtoreg == 2'b01) && (ex_rf != 5'd0) &&
                       ((ex_rf == id_rs) || (id_uses_rt && (ex_rf == id_rt)));
    end

    // ------------------------------------------------------------------
    // Control outputs: combinational, forced low while reset is asserted
    // ------------------------------------------------------------------
    always_comb begin
        mem_req      = 1'b0;
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        stall_idex   = 1'b0;
        stall_exmem  = 1'b0;
        bubble_memwb = 1'b0;
        if (reset) begin
            mem_req = access_state & mem_access;
            if (freeze) begin
                // Everything upstream of MEM holds; WB sees a bubble. Flushes
                // are suppressed so a pending redirect in EX is replayed when
                // the freeze drops.
                stall_pc     = 1'b1;
                stall_ifid   = 1'b1;
                stall_idex   = 1'b1;
                stall_exmem  = 1'b1;
                bubble_memwb = 1'b1;
            end else if (redirect) begin
                // The ID instruction is on the wrong path, so any load-use
                // hazard it has is irrelevant.
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else if (load_use) begin
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
                flush_idex = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            ST_RUN: begin
                // A ready access completes in the same cycle with no state change.
                if (freeze) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d    = ST_MEM_ERR;
                    wait_cnt_d = '0;
                    mem_err_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            ST_MEM_ERR: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign state_o = state_q;
    assign mem_err = mem_err_q;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturate at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_pc && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_ifid && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Table of single-cycle hazard vectors in RUN, followed by hand-written
// sequences for memory wait, timeout, freeze-vs-redirect, asynchronous reset
// mid-wait and the performance counters. Expected outputs are pushed to a
// scoreboard queue as stimulus is driven and popped when the outputs are
// sampled two time units later.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int TB_WAIT_MAX = 4;
    localparam int TB_CNT_W    = 2;

    // Control vector order:
    // {mem_req, stall_pc, stall_ifid, flush_ifid, flush_idex, stall_idex, stall_exmem, bubble_memwb}
    localparam logic [7:0] C_NONE   = 8'b0000_0000;
    localparam logic [7:0] C_REQ    = 8'b1000_0000;
    localparam logic [7:0] C_FREEZE = 8'b1110_0111;
    localparam logic [7:0] C_LU     = 8'b0110_1000;
    localparam logic [7:0] C_RD     = 8'b0001_1000;

    localparam logic [1:0] S_RUN  = 2'b00;
    localparam logic [1:0] S_WAIT = 2'b01;
    localparam logic [1:0] S_ERR  = 2'b10;

    logic                clk;
    logic                reset;
    logic [4:0]          id_rs, id_rt, ex_rf;
    logic                id_uses_rt;
    logic [1:0]          ex_memtoreg, ex_pcsrc;
    logic                mem_memwr, mem_memrd, mem_ready;
    logic                mem_req, stall_pc, stall_ifid, flush_ifid, flush_idex;
    logic                stall_idex, stall_exmem, bubble_memwb, mem_err;
    logic [1:0]          state_o;
    logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(
        .WAIT_MAX (TB_WAIT_MAX),
        .CNT_W    (TB_CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_memtoreg  (ex_memtoreg),
        .ex_rf        (ex_rf),
        .ex_pcsrc     (ex_pcsrc),
        .mem_memwr    (mem_memwr),
        .mem_memrd    (mem_memrd),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .stall_pc     (stall_pc),
        .stall_ifid   (stall_ifid),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .stall_idex   (stall_idex),
        .stall_exmem  (stall_exmem),
        .bubble_memwb (bubble_memwb),
        .mem_err      (mem_err),
        .state_o      (state_o),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic [1:0] m2r;
        logic [4:0] rf;
        logic [1:0] pcsrc;
        logic       memwr;
        logic       memrd;
        logic       ready;
        logic [7:0] ctrl;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] ctrl;
        logic [1:0] st;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[11];

    function automatic logic [7:0] act_ctrl();
        return {mem_req, stall_pc, stall_ifid, flush_ifid, flush_idex,
                stall_idex, stall_exmem, bubble_memwb};
    endfunction

    task automatic set_in(input vec_t v);
        id_rs       = v.rs;
        id_rt       = v.rt;
        id_uses_rt  = v.uses_rt;
        ex_memtoreg = v.m2r;
        ex_rf       = v.rf;
        ex_pcsrc    = v.pcsrc;
        mem_memwr   = v.memwr;
        mem_memrd   = v.memrd;
        mem_ready   = v.ready;
    endtask

    task automatic clear_in();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_memtoreg = 2'b00; ex_rf = 5'd0; ex_pcsrc = 2'b00;
        mem_memwr = 1'b0; mem_memrd = 1'b0; mem_ready = 1'b1;
    endtask

    // Load to $8 in EX while ID reads $8 through rs.
    task automatic set_load_use();
        ex_memtoreg = 2'b01; ex_rf = 5'd8; id_rs = 5'd8;
    endtask

    // Push the expectation for the inputs just driven, then sample and compare.
    task automatic check_now(input string nm, input logic [7:0] c,
                             input logic [1:0] st, input logic err);
        exp_t e;
        exp_t got;
        e.name = nm; e.ctrl = c; e.st = st; e.err = err;
        exp_q.push_back(e);
        #2;
        got = exp_q.pop_front();
        total++;
        if (act_ctrl() !== got.ctrl || state_o !== got.st || mem_err !== got.err) begin
            bad++;
            $display("FAIL %s: ctrl=%b state=%b err=%b, required ctrl=%b state=%b err=%b",
                     got.name, act_ctrl(), state_o, mem_err, got.ctrl, got.st, got.err);
        end else begin
            $display("chk %s: ctrl=%b state=%b err=%b", got.name, act_ctrl(), state_o, mem_err);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input string nm, input logic [7:0] c,
                         input logic [1:0] st, input logic err);
        check_now(nm, c, st, err);
        next_cycle();
    endtask

    task automatic check_cnt(input string nm, input logic [TB_CNT_W-1:0] es,
                             input logic [TB_CNT_W-1:0] ef);
        total++;
        if (stall_cnt !== es || flush_cnt !== ef) begin
            bad++;
            $display("FAIL %s: stall_cnt=%0d flush_cnt=%0d, required stall_cnt=%0d flush_cnt=%0d",
                     nm, stall_cnt, flush_cnt, es, ef);
        end else begin
            $display("chk %s: stall_cnt=%0d flush_cnt=%0d", nm, stall_cnt, flush_cnt);
        end
    endtask

    logic [TB_CNT_W-1:0] exp_s3, exp_f2, exp_sat;

    initial begin
        //          rs     rt     urt   m2r    rf     pcsrc  wr    rd    rdy   ctrl
        vecs[0]  = '{5'd8,  5'd0,  1'b0, 2'b01, 5'd8,  2'b00, 1'b0, 1'b0, 1'b1, C_LU};
        vecs[1]  = '{5'd0,  5'd0,  1'b1, 2'b01, 5'd0,  2'b00, 1'b0, 1'b0, 1'b1, C_NONE};
        vecs[2]  = '{5'd3,  5'd8,  1'b1, 2'b01, 5'd8,  2'b00, 1'b0, 1'b0, 1'b1, C_LU};
        vecs[3]  = '{5'd3,  5'd8,  1'b0, 2'b01, 5'd8,  2'b00, 1'b0, 1'b0, 1'b1, C_NONE};
        vecs[4]  = '{5'd8,  5'd0,  1'b0, 2'b00, 5'd8,  2'b00, 1'b0, 1'b0, 1'b1, C_NONE};
        vecs[5]  = '{5'd8,  5'd0,  1'b0, 2'b10, 5'd8,  2'b00, 1'b0, 1'b0, 1'b1, C_NONE};
        vecs[6]  = '{5'd8,  5'd0,  1'b0, 2'b01, 5'd8,  2'b01, 1'b0, 1'b0, 1'b1, C_RD};
        vecs[7]  = '{5'd1,  5'd2,  1'b1, 2'b00, 5'd9,  2'b10, 1'b0, 1'b0, 1'b1, C_RD};
        vecs[8]  = '{5'd1,  5'd2,  1'b1, 2'b00, 5'd9,  2'b00, 1'b0, 1'b1, 1'b1, C_REQ};
        vecs[9]  = '{5'd4,  5'd8,  1'b1, 2'b01, 5'd8,  2'b00, 1'b1, 1'b0, 1'b1, C_REQ | C_LU};
        vecs[10] = '{5'd4,  5'd8,  1'b1, 2'b01, 5'd8,  2'b11, 1'b1, 1'b0, 1'b1, C_REQ | C_RD};

`ifdef HAZ_PERF_CNT_EN
        exp_s3  = 2'd3; exp_f2 = 2'd2; exp_sat = 2'd3;
`else
        exp_s3  = 2'd0; exp_f2 = 2'd0; exp_sat = 2'd0;
`endif

        // Reset held low with hazard-provoking inputs: everything must be 0.
        reset = 1'b0;
        clear_in();
        set_load_use();
        ex_pcsrc  = 2'b01;
        mem_memrd = 1'b1;
        mem_ready = 1'b0;
        check_now("reset_hold", C_NONE, S_RUN, 1'b0);
        check_cnt("reset_cnt", '0, '0);

        clear_in();
        @(negedge clk);
        reset = 1'b1;
        next_cycle();

        // Performance counters: 3 load-use stalls, 2 redirects.
        for (int i = 0; i < 3; i++) begin
            clear_in(); set_load_use();
            cycle("cnt_lu", C_LU, S_RUN, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            clear_in(); ex_pcsrc = 2'b01;
            cycle("cnt_rd", C_RD, S_RUN, 1'b0);
        end
        clear_in();
        #2;
        check_cnt("cnt_3_2", exp_s3, exp_f2);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            clear_in(); set_load_use();
            cycle("cnt_lu_more", C_LU, S_RUN, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            clear_in(); ex_pcsrc = 2'b10;
            cycle("cnt_rd_more", C_RD, S_RUN, 1'b0);
        end
        clear_in();
        #2;
        check_cnt("cnt_saturate", exp_sat, exp_sat);
        next_cycle();

        // Single-cycle hazard table in RUN.
        for (int i = 0; i < 11; i++) begin
            set_in(vecs[i]);
            cycle($sformatf("vec%0d", i), vecs[i].ctrl, S_RUN, 1'b0);
        end

        // Load waits 3 cycles for the memory.
        clear_in(); mem_memrd = 1'b1; mem_ready = 1'b0;
        cycle("wait3_c0", C_FREEZE, S_RUN,  1'b0);
        cycle("wait3_c1", C_FREEZE, S_WAIT, 1'b0);
        cycle("wait3_c2", C_FREEZE, S_WAIT, 1'b0);
        mem_ready = 1'b1;
        cycle("wait3_done", C_REQ, S_WAIT, 1'b0);
        clear_in();
        cycle("wait3_run", C_NONE, S_RUN, 1'b0);

        // Redirect + load-use held during freeze, acted on when it drops.
        clear_in(); set_load_use(); ex_pcsrc = 2'b01;
        mem_memrd = 1'b1; mem_ready = 1'b0;
        cycle("frz_rd_c0", C_FREEZE, S_RUN,  1'b0);
        cycle("frz_rd_c1", C_FREEZE, S_WAIT, 1'b0);
        mem_ready = 1'b1;
        cycle("frz_rd_rel", C_REQ | C_RD, S_WAIT, 1'b0);
        clear_in();
        cycle("frz_rd_run", C_NONE, S_RUN, 1'b0);

        // Timeout: memory never ready.
        clear_in(); mem_memwr = 1'b1; mem_ready = 1'b0;
        cycle("tmo_c0", C_FREEZE, S_RUN, 1'b0);
        for (int i = 1; i <= TB_WAIT_MAX; i++)
            cycle($sformatf("tmo_wait%0d", i), C_FREEZE, S_WAIT, 1'b0);
        cycle("tmo_err", C_NONE, S_ERR, 1'b1);
        clear_in();
        cycle("tmo_run", C_NONE, S_RUN, 1'b1);
        set_load_use();
        cycle("tmo_sticky_lu", C_LU, S_RUN, 1'b1);

        // Reset pulled low in the middle of MEM_WAIT.
        clear_in(); mem_memrd = 1'b1; mem_ready = 1'b0;
        cycle("rst_c0", C_FREEZE, S_RUN, 1'b1);
        check_now("rst_c1", C_FREEZE, S_WAIT, 1'b1);
        reset = 1'b0;
        check_now("rst_async", C_NONE, S_RUN, 1'b0);
        @(negedge clk);
        clear_in();
        reset = 1'b1;
        next_cycle();
        set_load_use();
        cycle("rst_after_lu", C_LU, S_RUN, 1'b0);
        clear_in(); mem_memrd = 1'b1;
        cycle("rst_after_req", C_REQ, S_RUN, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
